// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send and
// shifts one command byte out on the device-generated clock, then checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_CYCLES = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_SEND    = 3'd3,
    ST_ACK     = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [3:0]       bit_cnt_r, bit_cnt_nxt_s;
  logic [9:0]       frame_r, frame_nxt_s;
  logic [2:0]       clk_sync_r, data_sync_r;
  logic             clk_oe_r, clk_oe_nxt_s;
  logic             data_oe_r, data_oe_nxt_s;
  logic             tx_ready_r, busy_r, tx_done_r, tx_error_r;
  logic             done_nxt_s, error_nxt_s;
  logic             fall_s, ack_low_s, bit_sel_s;

  assign fall_s    = ~clk_sync_r[1] & clk_sync_r[2];
  assign ack_low_s = ~data_sync_r[1];

  // Next state, counters and registered-output values for the transmit sequence.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_cnt_nxt_s = bit_cnt_r;
    frame_nxt_s   = frame_r;
    clk_oe_nxt_s  = 1'b0;
    data_oe_nxt_s = 1'b0;
    done_nxt_s    = 1'b0;
    error_nxt_s   = 1'b0;
    if (bit_cnt_r < 4'd10) begin
      bit_sel_s = frame_r[bit_cnt_r];
    end else begin
      bit_sel_s = 1'b1;
    end
    case (state_r)
      ST_IDLE: begin
        if (tx_valid && tx_ready_r) begin
          state_nxt_s  = ST_INHIBIT;
          cnt_nxt_s    = CNT_ZERO;
          frame_nxt_s  = {1'b1, odd_parity(tx_data), tx_data};
          clk_oe_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        clk_oe_nxt_s = 1'b1;
        if (cnt_r == INHIBIT_LAST) begin
          state_nxt_s   = ST_REQ;
          data_oe_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_REQ: begin
        state_nxt_s   = ST_SEND;
        cnt_nxt_s     = CNT_ZERO;
        bit_cnt_nxt_s = 4'd0;
        data_oe_nxt_s = 1'b1;
      end
      ST_SEND: begin
        data_oe_nxt_s = data_oe_r;
        if (fall_s) begin
          cnt_nxt_s     = CNT_ZERO;
          data_oe_nxt_s = ~bit_sel_s;
          bit_cnt_nxt_s = (bit_cnt_r == 4'd10) ? 4'd10 : bit_cnt_r + 4'd1;
          if (bit_cnt_r == 4'd9) begin
            state_nxt_s = ST_ACK;
          end else begin
            state_nxt_s = ST_SEND;
          end
        end else if (cnt_r == TIMEOUT_LAST) begin
          error_nxt_s   = 1'b1;
          data_oe_nxt_s = 1'b0;
          state_nxt_s   = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_ACK: begin
        if (fall_s) begin
          done_nxt_s  = ack_low_s;
          error_nxt_s = ~ack_low_s;
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_RELEASE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          error_nxt_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        // Wait for the device to let go of both lines before accepting again.
        if (clk_sync_r[2] && data_sync_r[2]) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, synchronisers and registered outputs; reset releases the pads at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      bit_cnt_r   <= 4'd0;
      frame_r     <= 10'd0;
      clk_sync_r  <= 3'b111;
      data_sync_r <= 3'b111;
      clk_oe_r    <= 1'b0;
      data_oe_r   <= 1'b0;
      tx_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      tx_done_r   <= 1'b0;
      tx_error_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      frame_r     <= frame_nxt_s;
      clk_sync_r  <= {clk_sync_r[1:0], ps2_clk};
      data_sync_r <= {data_sync_r[1:0], ps2_data};
      clk_oe_r    <= clk_oe_nxt_s;
      data_oe_r   <= data_oe_nxt_s;
      tx_ready_r  <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      tx_done_r   <= done_nxt_s;
      tx_error_r  <= error_nxt_s;
    end
  end

  assign tx_ready    = tx_ready_r;
  assign busy        = busy_r;
  assign tx_done     = tx_done_r;
  assign tx_error    = tx_error_r;
  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model plus a PS/2 device that clocks the
// frame in, samples each bit before its falling edge and optionally ACKs.
module tb_ps2_host_tx;

  localparam int INH    = 200;
  localparam int TO     = 1000;
  localparam int HP     = 25;
  localparam int SYNC   = 3;
  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_pad, ps2_data_pad;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  assign ps2_clk_pad  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pad = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk_pad), .ps2_data(ps2_data_pad),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
  end

  // Line image the device should see: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] expected_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = ((d >> i) & 8'd1) != 8'd0;
      ones += ((d >> i) & 1);
    end
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic dev_run(input int n_falls, input bit ack, output logic [10:0] bits, output int last_fall);
    int w;
    bits = 11'h7FF;
    last_fall = 0;
    w = 0;
    while (!(ps2_clk_pad && !ps2_data_pad) && w < BUDGET) begin
      @(posedge clk); #1; w++;
    end
    total++;
    if (w >= BUDGET) begin
      bad++;
      $display("FAIL dev_start: request-to-send not seen after %0d cycles, required < %0d", w, BUDGET);
    end else begin
      for (int k = 0; k < n_falls; k++) begin
        repeat (HP) @(posedge clk);
        #1;
        bits[k] = ps2_data_pad;
        dev_clk_low = 1'b1;
        if (k == 10 && ack) dev_data_low = 1'b1;
        last_fall = cyc;
        repeat (HP) @(posedge clk);
        #1;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int w;
    w = 0;
    while (!tx_ready && w < BUDGET) begin
      @(posedge clk); #1; w++;
    end
    total++;
    if (w >= BUDGET) begin
      bad++;
      $display("FAIL %s_ready: tx_ready=%b after %0d cycles, required 1", name, tx_ready, w);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    wait_ready("start");
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic test_frame(input logic [7:0] d, input bit ack, input string name);
    int d0, e0, inh, req, lf;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d);
    inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < INH + 50) begin
      inh++; @(posedge clk); #1;
    end
    req = 0;
    while (ps2_clk_oe && ps2_data_oe && req < 10) begin
      req++; @(posedge clk); #1;
    end
    total++;
    if (inh !== INH) begin bad++; $display("FAIL %s_inhibit: got %0d cycles, required %0d", name, inh, INH); end
    total++;
    if (req !== 1) begin bad++; $display("FAIL %s_req: got %0d cycles, required 1", name, req); end
    dev_run(11, ack, bits, lf);
    wait_ready(name);
    total++;
    if (bits !== expected_frame(d)) begin
      bad++; $display("FAIL %s_bits: got %b, required %b", name, bits, expected_frame(d));
    end
    total++;
    if (done_cnt - d0 !== (ack ? 1 : 0)) begin
      bad++; $display("FAIL %s_done: got %0d pulses, required %0d", name, done_cnt - d0, ack ? 1 : 0);
    end
    total++;
    if (err_cnt - e0 !== (ack ? 0 : 1)) begin
      bad++; $display("FAIL %s_error: got %0d pulses, required %0d", name, err_cnt - e0, ack ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe} !== 6'b100000) begin
      bad++; $display("FAIL reset_state: got %b, required 100000",
                      {tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    start_tx(8'h5A);
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (ps2_clk_oe !== 1'b1) begin bad++; $display("FAIL reset_pre_inhibit: clk_oe=%b, required 1", ps2_clk_oe); end
    #3 rst = 1'b1;
    #1;
    total++;
    if ({ps2_clk_oe, ps2_data_oe, busy, tx_ready} !== 4'b0001) begin
      bad++; $display("FAIL reset_inhibit: oe/busy/ready=%b, required 0001", {ps2_clk_oe, ps2_data_oe, busy, tx_ready});
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_send();
    logic [10:0] bits;
    int lf, d0, e0;
    logic [7:0] d;
    d  = 8'($urandom) & 8'hF7;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d);
    dev_run(4, 1'b0, bits, lf);
    total++;
    if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL midsend_data: data_oe=%b, required 1", ps2_data_oe); end
    #3 rst = 1'b1;
    #1;
    total++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      bad++; $display("FAIL midsend_release: oe=%b, required 00", {ps2_clk_oe, ps2_data_oe});
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({tx_ready, busy} !== 2'b10 || done_cnt != d0 || err_cnt != e0) begin
      bad++; $display("FAIL midsend_idle: ready/busy=%b pulses=%0d, required 10 and 0",
                      {tx_ready, busy}, (done_cnt - d0) + (err_cnt - e0));
    end
  endtask

  task automatic test_timeout();
    logic [10:0] bits;
    int lf, w, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'($urandom));
    dev_run(5, 1'b0, bits, lf);
    w = 0;
    while (!tx_error && w < TO + 100) begin
      @(posedge clk); #1; w++;
    end
    total++;
    if (cyc - lf !== TO + SYNC) begin
      bad++; $display("FAIL timeout_latency: got %0d cycles after pad fall, required %0d", cyc - lf, TO + SYNC);
    end
    total++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
      bad++; $display("FAIL timeout_release: oe/ready=%b, required 001", {ps2_clk_oe, ps2_data_oe, tx_ready});
    end
    @(posedge clk); #1;
    total++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      bad++; $display("FAIL timeout_pulses: err=%0d done=%0d, required 1 and 0", err_cnt - e0, done_cnt - d0);
    end
    test_frame(8'($urandom), 1'b1, "after_timeout");
  endtask

  task automatic test_back_to_back();
    logic [10:0] b1, b2;
    logic [7:0] d1, d2;
    int lf, w, d0;
    d1 = 8'($urandom);
    d2 = ~d1;
    d0 = done_cnt;
    wait_ready("b2b_first");
    tx_data  = d1;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = d2;
    total++;
    if ({tx_ready, busy} !== 2'b01) begin bad++; $display("FAIL b2b_busy: ready/busy=%b, required 01", {tx_ready, busy}); end
    dev_run(11, 1'b1, b1, lf);
    w = 0;
    while (!tx_ready && w < BUDGET) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept: busy=%b, required 1", busy); end
    dev_run(11, 1'b1, b2, lf);
    wait_ready("b2b");
    total++;
    if (b1 !== expected_frame(d1)) begin bad++; $display("FAIL b2b_frame1: got %b, required %b", b1, expected_frame(d1)); end
    total++;
    if (b2 !== expected_frame(d2)) begin bad++; $display("FAIL b2b_frame2: got %b, required %b", b2, expected_frame(d2)); end
    total++;
    if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_done: got %0d pulses, required 2", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_send();
    test_frame(8'hFF, 1'b1, "ff");
    test_frame(8'hF4, 1'b1, "f4");
    test_frame(8'hED, 1'b1, "ed");
    for (int i = 0; i < 3; i++) test_frame(8'($urandom), 1'b1, "rand");
    test_frame(8'($urandom), 1'b0, "noack");
    test_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
